bw_row_accumulator: RTL and testbench



---
 rtl/bw_row_accumulator.sv | 144 ++++++++++++++
 tb/tb_bw_row_accumulator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bw_row_accumulator.sv
// Row-serial reduction of 4x4 Baugh-Wooley partial products into an 8-bit signed product.
// Optional output register stage enabled by defining BW_OUT_REG_EN.
//
// state  | meaning
// IDLE   | waiting for a partial-product bundle
// ACC    | adding ROWS_PER_CYCLE shifted rows per cycle into acc
// DONE   | product complete, waiting for downstream acceptance
module bw_row_accumulator #(
    parameter int ROWS_PER_CYCLE = 1,
    parameter int PROD_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] pp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  product,
    output logic        busy
);

    if (ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 2) begin : g_bad_rows_per_cycle
        $error("bw_row_accumulator: ROWS_PER_CYCLE must be 1 or 2");
    end
    if (PROD_W != 8) begin : g_bad_prod_w
        $error("bw_row_accumulator: PROD_W must be 8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 2^7 + 2^4 restores the sign weighting removed by the complemented terms
    localparam logic [7:0] BW_CORR  = 8'h90;
    localparam logic [2:0] CNT_STEP = 3'(ROWS_PER_CYCLE);
    localparam logic [2:0] LAST_CNT = 3'(4 - ROWS_PER_CYCLE);

    state_t      state_q, state_d;
    logic [7:0]  acc_q, acc_d;
    logic [2:0]  row_cnt_q, row_cnt_d;
    logic [15:0] pp_q, pp_d;
    logic [7:0]  addend;
    logic        done_exit;

    function automatic logic [7:0] row_term(input logic [15:0] bits, input logic [1:0] r);
        logic [7:0] row;
        row = {4'b0000, bits[{r, 2'b00} +: 4]};
        return row << r;
    endfunction

`ifdef BW_OUT_REG_EN
    logic [7:0] oreg_q, oreg_d;
    logic       oreg_valid_q, oreg_valid_d;

    // the result flop can take a new value only if empty or being drained now
    assign done_exit = (state_q == S_DONE) && (!oreg_valid_q || out_ready);

    always_comb begin
        oreg_d       = oreg_q;
        oreg_valid_d = oreg_valid_q;
        if (oreg_valid_q && out_ready) begin
            oreg_valid_d = 1'b0;
        end
        if (done_exit) begin
            oreg_d       = acc_q;
            oreg_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_q       <= 8'h00;
            oreg_valid_q <= 1'b0;
        end else begin
            oreg_q       <= oreg_d;
            oreg_valid_q <= oreg_valid_d;
        end
    end

    assign out_valid = oreg_valid_q;
    assign product   = oreg_q;
`else
    assign done_exit = (state_q == S_DONE) && out_ready;
    assign out_valid = (state_q == S_DONE);
    assign product   = acc_q;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        row_cnt_d = row_cnt_q;
        pp_d      = pp_q;
        addend    = row_term(pp_q, row_cnt_q[1:0]);
        if (ROWS_PER_CYCLE == 2) begin
            addend = addend + row_term(pp_q, row_cnt_q[1:0] + 2'd1);
        end
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pp_d      = pp;
                    acc_d     = BW_CORR;
                    row_cnt_d = 3'd0;
                    state_d   = S_ACC;
                end
            end
            S_ACC: begin
                acc_d     = acc_q + addend;
                row_cnt_d = row_cnt_q + CNT_STEP;
                if (row_cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (done_exit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= 8'h00;
            row_cnt_q <= 3'd0;
            pp_q      <= 16'h0000;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            row_cnt_q <= row_cnt_d;
            pp_q      <= pp_d;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q == S_ACC) || (state_q == S_DONE);

endmodule

// File: tb/tb_bw_row_accumulator.sv
// Directed bench for bw_row_accumulator: one instance per ROWS_PER_CYCLE value, shared stimulus.
module tb_bw_row_accumulator;

`ifdef BW_OUT_REG_EN
    localparam int OREG = 1;
`else
    localparam int OREG = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] pp;
    logic        out_ready;
    logic        in_ready1, out_valid1, busy1;
    logic [7:0]  product1;
    logic        in_ready2, out_valid2, busy2;
    logic [7:0]  product2;

    int n_checks = 0;
    int n_errors = 0;

    bw_row_accumulator #(.ROWS_PER_CYCLE(1), .PROD_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .pp(pp),
        .out_valid(out_valid1), .out_ready(out_ready), .product(product1), .busy(busy1)
    );

    bw_row_accumulator #(.ROWS_PER_CYCLE(2), .PROD_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .pp(pp),
        .out_valid(out_valid2), .out_ready(out_ready), .product(product2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Baugh-Wooley partial-product generator, complemented terms applied
    function automatic logic [15:0] gen_pp(input int a, input int b);
        logic [3:0]  x, y;
        logic [15:0] v;
        x = a[3:0];
        y = b[3:0];
        for (int r = 0; r < 3; r++) begin
            v[4*r +: 3] = x[2:0] & {3{y[r]}};
            v[4*r + 3]  = ~(x[3] & y[r]);
        end
        v[14:12] = ~(x[2:0] & {3{y[3]}});
        v[15]    = x[3] & y[3];
        return v;
    endfunction

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(posedge clk); #1;
            ok = in_ready1 && in_ready2 && !out_valid1 && !out_valid2;
        end
        check_val(tag, ok, 1'b1);
    endtask

    task automatic do_mul(input int a, input int b, input bit chk_ready);
        logic [7:0] exp, p1, p2;
        int         lat1, lat2;
        bit         done;
        exp  = 8'(a * b);
        lat1 = -1;
        lat2 = -1;
        p1   = 8'h00;
        p2   = 8'h00;
        done = 0;
        @(negedge clk);
        in_valid = 1'b1;
        pp       = gen_pp(a, b);
        check_val("accept_ready", {in_ready1, in_ready2}, 2'b11);
        @(posedge clk); #1;
        in_valid = 1'b0;
        pp       = 16'($urandom);
        for (int c = 1; c <= 20 && !done; c++) begin
            @(posedge clk); #1;
            if (lat1 < 0 && out_valid1) begin lat1 = c; p1 = product1; end
            if (lat2 < 0 && out_valid2) begin lat2 = c; p2 = product2; end
            if (chk_ready && lat1 > 0 && c == lat1 + 1) check_val("ready_after_out", in_ready1, 1'b1);
            done = (lat1 > 0) && (lat2 > 0) && !out_valid1 && !out_valid2 && in_ready1 && in_ready2;
        end
        check_val("latency_rpc1", lat1, 4 + OREG);
        check_val("latency_rpc2", lat2, 2 + OREG);
        check_val($sformatf("product_rpc1 %0d*%0d", a, b), p1, exp);
        check_val($sformatf("product_rpc2 %0d*%0d", a, b), p2, exp);
        check_val("txn_timeout", done, 1'b1);
    endtask

    initial begin
        bit seen;
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pp        = 16'h0000;
        #3;
        check_val("rst_in_ready", in_ready1, 1'b1);
        check_val("rst_out_valid", out_valid1, 1'b0);
        check_val("rst_product", product1, 8'h00);
        check_val("rst_busy", busy1, 1'b0);

        // bundle waiting across reset release is taken on the first edge
        in_valid = 1'b1;
        pp       = gen_pp(1, -1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("accept_at_release", busy1, 1'b1);
        in_valid = 1'b0;
        wait_idle("release_idle");

        do_mul(3, 2, 1'b1);

        do_mul(-8, -8, 1'b0);
        do_mul(7, -8, 1'b0);
        do_mul(-1, -1, 1'b0);
        do_mul(0, -8, 1'b0);

        for (int ai = -8; ai < 8; ai++)
            for (int bi = -8; bi < 8; bi++)
                do_mul(ai, bi, 1'b0);

        // backpressure
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        pp       = gen_pp(-3, 5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(posedge clk); #1;
            seen = out_valid1;
        end
        check_val("stall_out_valid_seen", seen, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("stall_product", product1, 8'hF1);
            check_val("stall_out_valid", out_valid1, 1'b1);
`ifndef BW_OUT_REG_EN
            check_val("stall_in_ready", in_ready1, 1'b0);
            check_val("stall_busy", busy1, 1'b1);
            in_valid = 1'b1;
            pp       = gen_pp(1, 1);
`endif
        end
        @(negedge clk);
        check_val("stall_product_end", product1, 8'hF1);
        check_val("stall_product_rpc2", product2, 8'hF1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle("stall_release");

        // reset in the second ACC cycle
        @(negedge clk);
        in_valid = 1'b1;
        pp       = gen_pp(6, 7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_in_ready", in_ready1, 1'b1);
        check_val("midrst_busy", busy1, 1'b0);
        check_val("midrst_out_valid", out_valid1, 1'b0);
        check_val("midrst_product", product1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid1 || out_valid2) seen = 1;
        end
        check_val("midrst_no_out", seen, 1'b0);
        do_mul(2, -4, 1'b0);

`ifdef BW_OUT_REG_EN
        do_mul(5, 5, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        pp       = gen_pp(5, 5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (out_valid1) lat = c;
        end
        check_val("oreg_latency", lat, 5);
        check_val("oreg_product", product1, 8'h19);
        @(negedge clk);
        check_val("oreg_overlap_ready", {in_ready1, out_valid1}, 2'b11);
        in_valid = 1'b1;
        pp       = gen_pp(3, 3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("oreg_second_accepted", busy1, 1'b1);
        check_val("oreg_first_held", product1, 8'h19);
        @(negedge clk);
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(posedge clk); #1;
            seen = out_valid1 && (product1 == 8'h09);
        end
        check_val("oreg_second_product", seen, 1'b1);
        wait_idle("oreg_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
